// File: rtl/mips_cpu_hilo_muldiv_seq_if.sv
// Request/result bundle for the sequential HI/LO multiply-divide unit.
// Carries the optional div0 flag when MULDIV_DIV0_FLAG_EN is defined.
interface mips_cpu_hilo_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIV0_FLAG_EN
    logic             div0;

    modport master (output a, b, op, start, input busy, done, hi, lo, div0);
    modport slave  (input a, b, op, start, output busy, done, hi, lo, div0);
`else
    modport master (output a, b, op, start, input busy, done, hi, lo);
    modport slave  (input a, b, op, start, output busy, done, hi, lo);
`endif
endinterface

// File: rtl/mips_cpu_hilo_muldiv_seq.sv
// Sequential MIPS HI/LO unit: MULT/MULTU/DIV/DIVU in WIDTH+1 cycles, MTHI/MTLO immediate.
// Optional divide-by-zero flag output enabled by defining MULDIV_DIV0_FLAG_EN.
module mips_cpu_hilo_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    mips_cpu_hilo_muldiv_seq_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;      // product high half / partial remainder
    logic [WIDTH-1:0] lsr;      // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0] opd;      // multiplicand / divisor magnitude
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    // Request decode and operand magnitude capture.
    logic             accept;
    logic             move;
    logic             op_div;
    logic             b_zero;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        accept = 1'b0;
        move   = 1'b0;
        if (state == IDLE && bus.start) begin
            accept = ~bus.op[2];
            move   = (bus.op[2:1] == 2'b10);
        end
        op_div = ~bus.op[0];
        b_zero = (bus.b == '0);
        a_neg  = bus.op[1] & bus.a[WIDTH-1];
        b_neg  = bus.op[1] & bus.b[WIDTH-1];
        // A zero divisor keeps the raw dividend so the restoring loop leaves it in hi unchanged.
        a_mag  = (a_neg && !(op_div && b_zero)) ? -bus.a : bus.a;
        b_mag  = b_neg ? -bus.b : bus.b;
    end

    // One iteration of shift-add multiply and restoring divide.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc} + (lsr[0] ? {1'b0, opd} : '0);
        div_shift = {acc, lsr[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opd});
        div_diff  = div_shift - {1'b0, opd};
    end

    // Final sign correction applied in FIX.
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        product     = {acc, lsr};
        product_fix = neg_lo ? -product : product;
        quo_fix     = neg_lo ? -lsr : lsr;
        rem_fix     = neg_hi ? -acc : acc;
    end

`ifdef MULDIV_DIV0_FLAG_EN
    logic div_zero_q;
    logic div0_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            lsr    <= '0;
            opd    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
            div_zero_q <= 1'b0;
            div0_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
            div0_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= CALC;
                        cnt    <= '0;
                        acc    <= '0;
                        lsr    <= a_mag;
                        opd    <= b_mag;
                        is_div <= op_div;
                        if (op_div) begin
                            neg_lo <= (a_neg ^ b_neg) & ~b_zero;
                            neg_hi <= a_neg & ~b_zero;
                        end else begin
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg ^ b_neg;
                        end
`ifdef MULDIV_DIV0_FLAG_EN
                        div_zero_q <= op_div & b_zero;
`endif
                    end else if (move) begin
                        if (bus.op[0]) lo_q <= bus.a;
                        else           hi_q <= bus.a;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        lsr <= {lsr[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        lsr <= {mul_sum[0], lsr[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= product_fix[2*WIDTH-1:WIDTH];
                        lo_q <= product_fix[WIDTH-1:0];
                    end
                    done_q <= 1'b1;
`ifdef MULDIV_DIV0_FLAG_EN
                    div0_q <= div_zero_q;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
    assign bus.div0 = div0_q;
`endif

endmodule

// File: doc/mips_cpu_hilo_muldiv_seq.md
MIPS_CPU_HILO_MULDIV_SEQ -- requirements
Module: mips_cpu_hilo_muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width (>=8, even).
REQ-002 clk  input  1  single clock, all state updated on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO data).
REQ-005 b  input  WIDTH  operand B (divisor / multiplier).
REQ-006 op  input  3  000 DIVU, 001 MULTU, 010 DIV, 011 MULT, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-007 start  input  1  request strobe, sampled with a, b, op.
REQ-008 busy  output  1  high while an arithmetic operation is in progress.
REQ-009 done  output  1  one-cycle pulse, hi/lo hold a new arithmetic result.
REQ-010 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-011 FSM states IDLE, CALC, FIX; busy = (state != IDLE).
REQ-012 IDLE + start + op in {000..011}: latch operand magnitudes and sign info, clear iteration counter, go to CALC.
REQ-013 CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, exactly WIDTH cycles, then FIX.
REQ-014 FIX: apply sign correction, write hi/lo, assert done for the following cycle, return to IDLE.
REQ-015 Latency: start sampled at edge E0 -> hi/lo updated and done high after edge E0+WIDTH+1; busy high for exactly WIDTH+1 cycles.
REQ-016 start during the done cycle is accepted (back-to-back, no bubble).
REQ-017 start while busy is ignored; latched operands and op are not disturbed.
REQ-018 IDLE + start + op 100/101: hi/lo <= a at that edge; no busy, no done.
REQ-019 op 110/111: no state change, no done.
REQ-020 MULTU/MULT: {hi,lo} = full 2*WIDTH product, unsigned or two's-complement.
REQ-021 DIVU/DIV: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-022 Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
REQ-023 Divide by zero (b == 0): lo = all ones, hi = a (unsigned dividend value, any op); full latency, done still pulses.
REQ-024 hi/lo change only at REQ-014 or REQ-018 edges, otherwise hold.

Reset
REQ-025 reset_n low: state IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0, immediately and independent of clk.
REQ-026 Reset during CALC/FIX abandons the operation; no partial result reaches hi/lo.
REQ-027 First start accepted at the first rising edge after reset_n deasserts.

Configuration
REQ-028 Macro MULDIV_DIV0_FLAG_EN defined: extra output div0 (1 bit), high together with done when the completed operation was a divide with b == 0, else 0; reset value 0.
REQ-029 Macro MULDIV_DIV0_FLAG_EN undefined: no div0 port, no associated logic; all other behaviour identical.

Verification
REQ-030 WIDTH=32, MULTU a=FFFFFFFF b=FFFFFFFF -> after 33 edges done=1, hi=FFFFFFFE, lo=00000001.
REQ-031 DIV a=FFFFFFF9 (-7) b=00000002 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
REQ-032 DIVU a=00000064 b=0 -> lo=FFFFFFFF, hi=00000064, done=1, div0=1 when MULDIV_DIV0_FLAG_EN defined.
REQ-033 MULT a=5 b=3 started, second start MTHI a=1234 mid-CALC -> ignored; result hi=0, lo=0000000F; then MTHI in IDLE -> hi=00001234 next edge, done stays 0.
REQ-034 Back-to-back: second MULT started in done cycle -> second done exactly 33 cycles later.
REQ-035 reset_n pulsed low at CALC cycle 10 -> hi=lo=0, busy=0 asynchronously, no done afterwards.
